// File: rtl/atm_menu_pkg.sv
// Shared definitions for the ATM menu session sequencer: state encoding,
// operation codes and the per-operation scroller-reset mask helper.
package atm_menu_pkg;

   localparam int unsigned N_OPS = 4;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_BROWSE = 2'd1,
      ST_RUN    = 2'd2,
      ST_DONE   = 2'd3
   } state_t;

   typedef enum logic [1:0] {
      OP_BALANCE  = 2'd0,
      OP_WITHDRAW = 2'd1,
      OP_CURRENCY = 2'd2,
      OP_TRANSFER = 2'd3
   } op_t;

   // All scrollers held in reset except the one for the selected operation.
   function automatic logic [N_OPS-1:0] rst_mask(input logic [1:0] sel);
      logic [N_OPS-1:0] one;
      one = {{(N_OPS-1){1'b0}}, 1'b1};
      return ~(one << sel);
   endfunction

endpackage

// File: rtl/atm_menu_ctrl_btn_edge.sv
// Rising-edge detector for one debounced button level: one press gives a
// single-cycle pulse, a held level gives nothing further.
module btn_edge (
   input  logic clk,
   input  logic rst_n,
   input  logic level,
   output logic pulse
);

   logic prev;

   // Remember last cycle's level to spot the low-to-high transition.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) prev <= 1'b0;
      else        prev <= level;
   end

   assign pulse = level & ~prev;

endmodule

// File: rtl/atm_menu_ctrl.sv
// ATM front-panel session sequencer: IDLE / BROWSE / RUN / DONE over the four
// operations, driving scroller resets, display-mux select and start/abort pulses.
// Optional feature macro: MENU_TIMEOUT_EN (BROWSE inactivity timeout back to IDLE).
module atm_menu_ctrl
   import atm_menu_pkg::*;
#(
   parameter int unsigned TIMEOUT_TICKS = 30,
   parameter int unsigned DONE_HOLD     = 5
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             tick_1hz,
   input  logic             btn_up,
   input  logic             btn_down,
   input  logic             btn_sel,
   input  logic             btn_back,
   input  logic             op_done,
   output logic [1:0]       op_sel,
   output logic [N_OPS-1:0] inst_rst,
   output logic             op_start,
   output logic             op_abort,
   output logic             busy,
   output logic [1:0]       state_o
);

   localparam int unsigned CNT_MAX = (TIMEOUT_TICKS > DONE_HOLD) ? TIMEOUT_TICKS : DONE_HOLD;
   localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);

   logic up_p, down_p, sel_p, back_p;

   btn_edge u_edge_up   (.clk(clk), .rst_n(rst_n), .level(btn_up),   .pulse(up_p));
   btn_edge u_edge_down (.clk(clk), .rst_n(rst_n), .level(btn_down), .pulse(down_p));
   btn_edge u_edge_sel  (.clk(clk), .rst_n(rst_n), .level(btn_sel),  .pulse(sel_p));
   btn_edge u_edge_back (.clk(clk), .rst_n(rst_n), .level(btn_back), .pulse(back_p));

   state_t             state, state_n;
   logic [1:0]         op_sel_n;
   logic [CNT_W-1:0]   cnt, cnt_n;
   logic [N_OPS-1:0]   inst_rst_n;
   logic               start_n, abort_n, busy_n;
   logic               any_press, press_acc;

   // Next-state, selection, counter and registered-output decode.
   always_comb begin
      state_n  = state;
      op_sel_n = op_sel;
      cnt_n    = cnt;
      start_n  = 1'b0;
      abort_n  = 1'b0;

      any_press = up_p | down_p | sel_p | back_p;
      // In RUN only back is acted on; elsewhere every press counts.
      press_acc = (state == ST_RUN) ? back_p : any_press;

      case (state)
         ST_IDLE: begin
            if (any_press) begin
               state_n  = ST_BROWSE;
               op_sel_n = OP_BALANCE;
            end
         end
         ST_BROWSE: begin
            if (back_p) begin
               state_n = ST_IDLE;
            end else if (sel_p) begin
               state_n = ST_RUN;
               start_n = 1'b1;
            end else if (up_p) begin
               op_sel_n = op_sel + 2'd1;
            end else if (down_p) begin
               op_sel_n = op_sel - 2'd1;
            end
`ifdef MENU_TIMEOUT_EN
            else if (tick_1hz) begin
               if (cnt == CNT_W'(TIMEOUT_TICKS - 1)) state_n = ST_IDLE;
               else                                  cnt_n   = cnt + 1'b1;
            end
`endif
         end
         ST_RUN: begin
            if (op_done) begin
               state_n = ST_DONE;
            end else if (back_p) begin
               state_n = ST_BROWSE;
               abort_n = 1'b1;
            end
         end
         ST_DONE: begin
            if (any_press) begin
               state_n = ST_BROWSE;
            end else if (tick_1hz) begin
               if (cnt == CNT_W'(DONE_HOLD - 1)) state_n = ST_BROWSE;
               else                              cnt_n   = cnt + 1'b1;
            end
         end
         default: state_n = ST_IDLE;
      endcase

      // A press or a state change restarts the count, even if a tick coincides.
      if ((state_n != state) || press_acc) cnt_n = '0;

      inst_rst_n = (state_n == ST_IDLE) ? '1 : rst_mask(op_sel_n);
      busy_n     = (state_n == ST_RUN);
   end

   // State, selection, counter and output registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= ST_IDLE;
         op_sel   <= '0;
         cnt      <= '0;
         inst_rst <= '1;
         op_start <= 1'b0;
         op_abort <= 1'b0;
         busy     <= 1'b0;
      end else begin
         state    <= state_n;
         op_sel   <= op_sel_n;
         cnt      <= cnt_n;
         inst_rst <= inst_rst_n;
         op_start <= start_n;
         op_abort <= abort_n;
         busy     <= busy_n;
      end
   end

   assign state_o = state;

endmodule
